// File: rtl/TicSAT_pkg.sv
// -----------------------------------------------------------------------------
// TicSAT_pkg
// Shared types for the TicSAT systolic-array datapath and its sequencer.
//   command_t   : command word presented to the array on every clock
//   seq_state_t : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package TicSAT_pkg;

    typedef enum logic [2:0] {
        CMD_NONE         = 3'd0,
        CMD_WRITE_WEIGHT = 3'd1,
        CMD_WRITE_INPUT  = 3'd2,
        CMD_STREAM       = 3'd3,
        CMD_READ_OUTPUT  = 3'd4
    } command_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_A = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        READ   = 3'd5,
        DONE   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/sa_sequencer.sv
// -----------------------------------------------------------------------------
// sa_sequencer
// Job sequencer for a SA_SIZE x SA_SIZE systolic array (TicSAT_FP32_Int8).
// One job: optional weight load (SA_SIZE*SA_SIZE beats), then per activation
// row: load SA_SIZE inputs, one stream command, DRAIN_CYCLES idle cycles and
// SA_SIZE result reads. A one-cycle done pulse closes the job.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   start, reuse_w, num_rows    job request (start honoured only when idle)
//   busy, done                  status; done is a one-cycle pulse
//   w_valid/w_ready/w_data      weight stream in
//   a_valid/a_ready/a_data      activation stream in
//   r_valid/r_ready/r_data      result stream out (r_data = sa_out)
//   sa_in_val/sa_in_idx/sa_cmd  array command side
//   sa_out                      array read data
//   perf_cycles                 busy-cycle count of the current job
//                               (only with SA_SEQ_PERF_CNT_EN defined)
//
// Build option: define SA_SEQ_PERF_CNT_EN to add the perf_cycles counter.
// DRAIN_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module sa_sequencer
    import TicSAT_pkg::*;
#(
    parameter int SA_SIZE         = 4,
    parameter int ACTIVATION_SIZE = 32,
    parameter int DRAIN_CYCLES    = 2 * SA_SIZE
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         reuse_w,
    input  logic [15:0]                  num_rows,
    output logic                         busy,
    output logic                         done,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [ACTIVATION_SIZE-1:0]   w_data,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [ACTIVATION_SIZE-1:0]   a_data,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [ACTIVATION_SIZE-1:0]   r_data,
    output logic [ACTIVATION_SIZE-1:0]   sa_in_val,
    output logic [$clog2(SA_SIZE)-1:0]   sa_in_idx,
    output command_t                     sa_cmd,
    input  logic [ACTIVATION_SIZE-1:0]   sa_out
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_cycles
`endif
);

    localparam int IDXW = $clog2(SA_SIZE);
    localparam int WCW  = $clog2(SA_SIZE * SA_SIZE);
    localparam int DCW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(SA_SIZE - 1);
    localparam logic [WCW-1:0]  WCNT_LAST  = WCW'(SA_SIZE * SA_SIZE - 1);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [WCW-1:0]     w_cnt_q, w_cnt_d;
    logic [IDXW-1:0]    idx_q,   idx_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic [15:0]        rows_q,  rows_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            w_cnt_q <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            w_cnt_q <= w_cnt_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            rows_q  <= rows_d;
        end
    end

    // The shared index register serves both the input-load beat index and
    // the result-read column; both phases always leave it wrapped to 0.
    assign sa_in_idx = idx_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        w_cnt_d   = w_cnt_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        rows_d    = rows_q;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        r_valid   = 1'b0;
        r_data    = '0;
        done      = 1'b0;
        sa_cmd    = CMD_NONE;
        sa_in_val = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d  = num_rows;
                    w_cnt_d = '0;
                    idx_d   = '0;
                    drain_d = '0;
                    if (num_rows == 16'd0) begin
                        state_d = DONE;
                    end else if (reuse_w) begin
                        state_d = LOAD_A;
                    end else begin
                        state_d = LOAD_W;
                    end
                end
            end

            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    sa_cmd    = CMD_WRITE_WEIGHT;
                    sa_in_val = w_data;
                    w_cnt_d   = w_cnt_q + WCW'(1);
                    if (w_cnt_q == WCNT_LAST) begin
                        state_d = LOAD_A;
                    end
                end
            end

            LOAD_A: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    sa_cmd    = CMD_WRITE_INPUT;
                    sa_in_val = a_data;
                    idx_d     = idx_q + IDXW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STREAM;
                    end
                end
            end

            STREAM: begin
                sa_cmd  = CMD_STREAM;
                state_d = DRAIN;
            end

            DRAIN: begin
                drain_d = drain_q + DCW'(1);
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = READ;
                end
            end

            READ: begin
                r_valid = 1'b1;
                r_data  = sa_out;
                if (r_ready) begin
                    sa_cmd = CMD_READ_OUTPUT;
                    idx_d  = idx_q + IDXW'(1);
                    if (idx_q == IDX_LAST) begin
                        rows_d  = rows_q - 16'd1;
                        state_d = (rows_q == 16'd1) ? DONE : LOAD_A;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    // Cleared when a job is accepted; stops in IDLE so the last job's count
    // stays readable after done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else if (state_q == IDLE && start) begin
            perf_q <= '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sa_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sa_sequencer
// Directed bench for sa_sequencer at SA_SIZE=4, ACTIVATION_SIZE=32,
// DRAIN_CYCLES=8. The array is modelled as sa_out = 0xC0DE0000 + sa_in_idx.
// A negedge monitor tallies commands per job; directed jobs then compare the
// tallies and timings against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sa_sequencer;
    import TicSAT_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, reuse_w;
    logic [15:0] num_rows;
    logic        busy, done;
    logic        w_valid, w_ready, a_valid, a_ready, r_valid, r_ready;
    logic [31:0] w_data, a_data, r_data, sa_in_val, sa_out;
    logic [1:0]  sa_in_idx;
    command_t    sa_cmd;
`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    logic [31:0] cyc = 32'd0;
    logic        wv_toggle, wv_lvl;

    int n_checks = 0;
    int n_fail   = 0;

    // per-job monitor tallies
    int          n_ww, n_wi, n_st, n_ro, n_cmd, n_done, n_bad, gap, last_gap;
    bit          in_gap;
    logic [31:0] done_cyc, t0;

    sa_sequencer #(
        .SA_SIZE(4),
        .ACTIVATION_SIZE(32),
        .DRAIN_CYCLES(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .start(start), .reuse_w(reuse_w), .num_rows(num_rows),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .sa_in_val(sa_in_val), .sa_in_idx(sa_in_idx), .sa_cmd(sa_cmd),
        .sa_out(sa_out)
`ifdef SA_SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    assign w_data  = 32'h1000_0000 | cyc;
    assign a_data  = 32'h2000_0000 | cyc;
    assign w_valid = wv_toggle ? cyc[0] : wv_lvl;
    assign sa_out  = 32'hC0DE_0000 + {30'd0, sa_in_idx};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Monitor: every issued command must match a handshake and carry the
    // right data/index; every handshake must produce a command.
    always @(negedge clk) begin
        if (resetn) begin
            if (sa_cmd != CMD_NONE) n_cmd++;
            case (sa_cmd)
                CMD_WRITE_WEIGHT: begin
                    if (!(w_valid && w_ready) || sa_in_val != w_data) n_bad++;
                    n_ww++;
                end
                CMD_WRITE_INPUT: begin
                    if (!(a_valid && a_ready) || sa_in_val != a_data
                        || int'(sa_in_idx) != (n_wi % 4)) n_bad++;
                    n_wi++;
                end
                CMD_STREAM: begin
                    n_st++;
                    gap    = 0;
                    in_gap = 1'b1;
                end
                CMD_READ_OUTPUT: begin
                    if (!(r_valid && r_ready) || int'(sa_in_idx) != (n_ro % 4)
                        || r_data != (32'hC0DE_0000 + 32'(n_ro % 4))) n_bad++;
                    n_ro++;
                    if (in_gap) begin
                        last_gap = gap;
                        in_gap   = 1'b0;
                    end
                end
                default: begin
                    if (in_gap) gap++;
                    if ((w_valid && w_ready) || (a_valid && a_ready) || (r_valid && r_ready)) n_bad++;
                end
            endcase
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // t0 is the cycle in which start is high; the capture edge ends it.
    task automatic start_job(input logic rw, input logic [15:0] nr);
        @(posedge clk);
        #1;
        n_ww = 0; n_wi = 0; n_st = 0; n_ro = 0; n_cmd = 0; n_done = 0;
        n_bad = 0; gap = 0; last_gap = -1; in_gap = 1'b0; done_cyc = 32'd0;
        start    = 1'b1;
        reuse_w  = rw;
        num_rows = nr;
        t0       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for a done pulse within budget, then a few more cycles so a
    // second pulse would also be counted.
    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_done_cnt"}, 32'(n_done), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_cmd"}, 32'(sa_cmd), 32'(CMD_NONE));
        check_val({tag, "_idx"}, 32'(sa_in_idx), 32'd0);
        check_val({tag, "_val"}, sa_in_val, 32'd0);
        check_val({tag, "_rdy_vld"}, {29'd0, w_ready, a_ready, r_valid}, 32'd0);
    endtask

    initial begin
        int k;
        resetn    = 1'b0;
        start     = 1'b0;
        reuse_w   = 1'b0;
        num_rows  = 16'd0;
        wv_toggle = 1'b0;
        wv_lvl    = 1'b1;
        a_valid   = 1'b1;
        r_ready   = 1'b1;
        n_done    = 0;

        #3;
        check_quiet("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Job 1: full weight load, one row, everything always ready.
        // LOAD_W 1..16, LOAD_A 17..20, STREAM 21, DRAIN 22..29, READ 30..33, DONE 34.
        start_job(1'b0, 16'd1);
        wait_done("job1", 200);
        check_val("job1_ww", 32'(n_ww), 32'd16);
        check_val("job1_wi", 32'(n_wi), 32'd4);
        check_val("job1_stream", 32'(n_st), 32'd1);
        check_val("job1_reads", 32'(n_ro), 32'd4);
        check_val("job1_drain_gap", 32'(last_gap), 32'd8);
        check_val("job1_latency", done_cyc - t0, 32'd34);
        check_val("job1_cmds", 32'(n_cmd), 32'd25);
        check_val("job1_bad", 32'(n_bad), 32'd0);
        check_val("job1_idle_busy", 32'(busy), 32'd0);
`ifdef SA_SEQ_PERF_CNT_EN
        check_val("job1_perf", perf_cycles, 32'd34);
`endif

        // Job 2: reuse weights, three rows; a start pulse mid-job is ignored.
        start_job(1'b1, 16'd3);
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        reuse_w  = 1'b0;
        num_rows = 16'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("job2", 300);
        check_val("job2_ww", 32'(n_ww), 32'd0);
        check_val("job2_wi", 32'(n_wi), 32'd12);
        check_val("job2_stream", 32'(n_st), 32'd3);
        check_val("job2_reads", 32'(n_ro), 32'd12);
        check_val("job2_latency", done_cyc - t0, 32'd52);
        check_val("job2_bad", 32'(n_bad), 32'd0);

        // Job 3: w_valid toggles every cycle.
        wv_toggle = 1'b1;
        start_job(1'b0, 16'd1);
        wait_done("job3", 300);
        wv_toggle = 1'b0;
        check_val("job3_ww", 32'(n_ww), 32'd16);
        check_val("job3_reads", 32'(n_ro), 32'd4);
        check_val("job3_bad", 32'(n_bad), 32'd0);

        // Job 4: r_ready low for 5 cycles after the second read beat.
        start_job(1'b1, 16'd1);
        k = 0;
        while (n_ro < 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val("job4_reach_read", 32'(n_ro), 32'd2);
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check_val("job4_stall_idx", 32'(sa_in_idx), 32'd2);
            check_val("job4_stall_rdata", r_data, 32'hC0DE_0002);
            check_val("job4_stall_cmd", 32'(sa_cmd), 32'(CMD_NONE));
        end
        @(posedge clk);
        #1;
        r_ready = 1'b1;
        wait_done("job4", 200);
        check_val("job4_reads", 32'(n_ro), 32'd4);
        check_val("job4_bad", 32'(n_bad), 32'd0);

        // Job 5: zero rows -> straight to DONE, no array commands.
        start_job(1'b0, 16'd0);
        wait_done("job5", 20);
        check_val("job5_latency", done_cyc - t0, 32'd1);
        check_val("job5_cmds", 32'(n_cmd), 32'd0);

        // Job 6: reset during DRAIN abandons the job.
        start_job(1'b1, 16'd1);
        k = 0;
        while (n_st == 0 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #2;
        check_val("job6_in_drain_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check_quiet("job6_rst");
        @(posedge clk);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("job6_no_done", 32'(n_done), 32'd0);
        check_val("job6_idle", 32'(busy), 32'd0);

        // Job 7: a fresh job after the abandoned one runs normally.
        start_job(1'b0, 16'd1);
        wait_done("job7", 200);
        check_val("job7_ww", 32'(n_ww), 32'd16);
        check_val("job7_reads", 32'(n_ro), 32'd4);
        check_val("job7_latency", done_cyc - t0, 32'd34);
        check_val("job7_bad", 32'(n_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_sequencer.md
SA_SEQUENCER -- requirements
Module: sa_sequencer

Interface
REQ-001 SHALL have parameter SA_SIZE, default 4, array dimension (power of 2, >=2).
REQ-002 SHALL have parameter ACTIVATION_SIZE, default 32, data word width.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2*SA_SIZE, wait between stream and readout.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports start in 1 (pulse), reuse_w in 1, num_rows in 16: job request, weight-reuse flag and activation-row count.
REQ-007 SHALL have ports busy out 1 and done out 1 (one-cycle pulse).
REQ-008 SHALL have ports w_valid in 1, w_ready out 1, w_data in ACTIVATION_SIZE: weight stream.
REQ-009 SHALL have ports a_valid in 1, a_ready out 1, a_data in ACTIVATION_SIZE: activation stream.
REQ-010 SHALL have ports r_valid out 1, r_ready in 1, r_data out ACTIVATION_SIZE: result stream.
REQ-011 SHALL have array-side ports sa_in_val out ACTIVATION_SIZE, sa_in_idx out $clog2(SA_SIZE), sa_cmd out command_t, sa_out in ACTIVATION_SIZE.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_W, LOAD_A, STREAM, DRAIN, READ, DONE.
REQ-013 IDLE + start: latch num_rows and reuse_w; go LOAD_W if reuse_w=0, else LOAD_A; if num_rows=0, go DONE without any array command.
REQ-014 LOAD_W: w_ready=1; each w_valid&w_ready beat drives sa_cmd=CMD_WRITE_WEIGHT, sa_in_val=w_data; after SA_SIZE*SA_SIZE beats go LOAD_A.
REQ-015 LOAD_A: a_ready=1; each beat drives sa_cmd=CMD_WRITE_INPUT, sa_in_val=a_data, sa_in_idx=beat index 0..SA_SIZE-1; after SA_SIZE beats go STREAM.
REQ-016 STREAM: exactly one cycle of sa_cmd=CMD_STREAM, then DRAIN.
REQ-017 DRAIN: count DRAIN_CYCLES cycles with sa_cmd=CMD_NONE, then READ.
REQ-018 READ: r_valid=1, sa_in_idx=k, r_data=sa_out combinationally; on r_valid&r_ready drive sa_cmd=CMD_READ_OUTPUT, k++; after SA_SIZE beats decrement row counter; go LOAD_A if rows remain, else DONE.
REQ-019 DONE: done=1 for one cycle, then IDLE.
REQ-020 sa_cmd SHALL be CMD_NONE on every cycle without a completed handshake (valid low or ready low).
REQ-021 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-022 w_ready, a_ready, r_valid SHALL be 0 outside LOAD_W, LOAD_A, READ respectively.
REQ-023 sa_in_idx SHALL hold its value while waiting for a handshake; wraps to 0 after SA_SIZE-1.
REQ-024 Weight-load counter width $clog2(SA_SIZE*SA_SIZE); row counter 16 bits, no overflow possible.

Reset
REQ-025 resetn low SHALL immediately force IDLE, all counters 0, busy=0, done=0, ready/valid outputs 0, sa_cmd=CMD_NONE, sa_in_idx=0, sa_in_val=0.
REQ-026 Reset mid-job SHALL abandon the job; no done pulse; next start begins fresh.

Configuration
REQ-027 With SA_SEQ_PERF_CNT_EN defined: output perf_cycles (32 bits) counts cycles with busy=1 in the current job, cleared on start, held after done, saturating at all-ones.
REQ-028 Without SA_SEQ_PERF_CNT_EN: port and counter absent; all other behaviour identical.

Structure
REQ-029 command_t and its values (CMD_NONE, CMD_WRITE_WEIGHT, CMD_WRITE_INPUT, CMD_STREAM, CMD_READ_OUTPUT) SHALL come from TicSAT_pkg; the FSM state enum seq_state_t SHALL be added to TicSAT_pkg.
REQ-030 Single module; no sub-modules; intended to drive TicSAT_FP32_Int8 (in_val, in_idx, cmd, out) directly.

Verification
REQ-031 SA_SIZE=4, reuse_w=0, num_rows=1, all valid/ready held high -> 16 CMD_WRITE_WEIGHT, 4 CMD_WRITE_INPUT idx 0..3, 1 CMD_STREAM, 8 idle, 4 reads; done at cycle 34 after start.
REQ-032 reuse_w=1, num_rows=3 -> no CMD_WRITE_WEIGHT; 3 load/stream/drain/read loops; 12 result beats; single done.
REQ-033 w_valid toggling 1/0 each cycle -> CMD_WRITE_WEIGHT only on valid cycles; exactly 16 issued.
REQ-034 r_ready low 5 cycles mid-READ -> r_data, sa_in_idx stable, sa_cmd=CMD_NONE; no lost or duplicated beat.
REQ-035 num_rows=0 -> done one cycle after DONE entry, zero non-NONE commands; start during busy ignored.
REQ-036 resetn asserted in DRAIN -> all outputs at reset values same cycle; no done; following job completes normally.
